// File: rtl/alu_muldiv.sv
// ALU with combinational single-cycle ops plus an iterative shift-add multiplier
// and restoring divider that share one HI/LO result pair.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [4:0]       ALUCtrl,
  input  logic             Sign,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_NOR  = 5'b01000;
  localparam logic [4:0] OP_XOR  = 5'b01001;
  localparam logic [4:0] OP_SLL  = 5'b01010;
  localparam logic [4:0] OP_SRL  = 5'b10000;
  localparam logic [4:0] OP_SRA  = 5'b10001;
  localparam logic [4:0] OP_MULT = 5'b10010;
  localparam logic [4:0] OP_DIV  = 5'b10011;
  localparam logic [4:0] OP_MFHI = 5'b10100;
  localparam logic [4:0] OP_MFLO = 5'b10101;

  localparam int CW = SHW + 1;
  localparam logic [CW-1:0]      CNT_END = CW'(WIDTH);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + ONE_W) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + ONE_2W) : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return cneg_w(v, sgn & v[WIDTH-1]);
  endfunction

  logic signed [WIDTH-1:0] in1_s, in2_s;
  logic [SHW-1:0]          shamt;

  assign in1_s = in1;
  assign in2_s = in2;
  assign shamt = in1[SHW-1:0];

  always_comb begin
    out = '0;
    case (ALUCtrl)
      OP_AND:  out = in1 & in2;
      OP_OR:   out = in1 | in2;
      OP_ADD:  out = in1 + in2;
      OP_SUB:  out = in1 - in2;
      OP_SLT:  out = {{(WIDTH-1){1'b0}}, (Sign ? (in1_s < in2_s) : (in1 < in2))};
      OP_NOR:  out = ~(in1 | in2);
      OP_XOR:  out = in1 ^ in2;
      OP_SLL:  out = in2 << shamt;
      OP_SRL:  out = in2 >> shamt;
      OP_SRA:  out = in2_s >>> shamt;
      OP_MFHI: out = hi;
      OP_MFLO: out = lo;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             div_q, div_d, sign_q, sign_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     madd, dsh;
  logic               ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               launch;

  assign mag_a  = mag(a_q, sign_q);
  assign mag_b  = mag(b_q, sign_q);
  // acc_hi:acc_lo is the shifting product (mult) or remainder:quotient pair (div)
  assign madd   = acc_lo_q[0] ? ({1'b0, acc_hi_q} + {1'b0, mag_a}) : {1'b0, acc_hi_q};
  assign dsh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign ge     = (dsh >= {1'b0, mag_b});
  assign prod   = {acc_hi_q, acc_lo_q};
  assign launch = start && ((ALUCtrl == OP_MULT) || (ALUCtrl == OP_DIV));

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (!div_q) begin
      {res_hi, res_lo} = cneg_2w(prod, sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]));
    end else if (b_q == '0) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_lo = cneg_w(acc_lo_q, sign_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]));
      res_hi = cneg_w(acc_hi_q, sign_q & a_q[WIDTH-1]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    div_d    = div_q;
    sign_d   = sign_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          state_d  = RUN;
          busy_d   = 1'b1;
          cnt_d    = '0;
          a_d      = in1;
          b_d      = in2;
          div_d    = (ALUCtrl == OP_DIV);
          sign_d   = Sign;
          acc_hi_d = '0;
          acc_lo_d = (ALUCtrl == OP_DIV) ? mag(in1, Sign) : mag(in2, Sign);
        end
      end
      RUN: begin
        // counts 0..WIDTH-1 are the iteration steps; the terminal count commits HI/LO
        if (cnt_q == CNT_END) begin
          state_d = FIN;
          done_d  = 1'b1;
          hi_d    = res_hi;
          lo_d    = res_lo;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (div_q) begin
            acc_hi_d = ge ? WIDTH'(dsh - {1'b0, mag_b}) : dsh[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], ge};
          end else begin
            acc_hi_d = madd[WIDTH:1];
            acc_lo_d = {madd[0], acc_lo_q[WIDTH-1:1]};
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      div_q    <= 1'b0;
      sign_q   <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      div_q    <= div_d;
      sign_q   <= sign_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv (WIDTH=32): combinational vector table applied while the
// iterative unit is busy, plus mult/div sequences checked through a result queue.
module tb_alu_muldiv;

  localparam int W = 32;

  localparam logic [4:0] C_AND  = 5'b00000;
  localparam logic [4:0] C_OR   = 5'b00001;
  localparam logic [4:0] C_ADD  = 5'b00010;
  localparam logic [4:0] C_SUB  = 5'b00110;
  localparam logic [4:0] C_SLT  = 5'b00111;
  localparam logic [4:0] C_NOR  = 5'b01000;
  localparam logic [4:0] C_XOR  = 5'b01001;
  localparam logic [4:0] C_SLL  = 5'b01010;
  localparam logic [4:0] C_SRL  = 5'b10000;
  localparam logic [4:0] C_SRA  = 5'b10001;
  localparam logic [4:0] C_MULT = 5'b10010;
  localparam logic [4:0] C_DIV  = 5'b10011;
  localparam logic [4:0] C_MFHI = 5'b10100;
  localparam logic [4:0] C_MFLO = 5'b10101;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic [4:0]   ALUCtrl = '0;
  logic         Sign = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] out, hi, lo;
  logic         zero, busy, done;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .in1(in1), .in2(in2), .ALUCtrl(ALUCtrl),
    .Sign(Sign), .start(start), .out(out), .zero(zero), .busy(busy),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   ctrl;
    logic         sign;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_out;
    logic         exp_zero;
  } vec_t;

  vec_t        vecs [17];
  logic [63:0] exp_q [$];
  logic [63:0] mon_exp;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;
  int          snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest queued HI/LO expectation
  always @(negedge clk) begin
    if (reset_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got hi=%0h lo=%0h expected no result", hi, lo);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result_hilo", {hi, lo}, mon_exp);
      end
    end
  end

  task automatic launch(input logic [4:0] c, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic push,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    @(negedge clk);
    ALUCtrl = c; Sign = s; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) exp_q.push_back({eh, el});
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic wait_done(input int exp_lat, input string name);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done in %0d cycles expected done", name, n);
    end else begin
      if (exp_lat > 0) check({name, "_latency"}, 64'(n), 64'(exp_lat));
      check({name, "_busy_in_done"}, {63'd0, busy}, 64'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{C_AND,  1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0};
    vecs[1]  = '{C_OR,   1'b0, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0};
    vecs[2]  = '{C_ADD,  1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 1'b0};
    vecs[3]  = '{C_SUB,  1'b0, 32'd5,         32'd5,         32'h0000_0000, 1'b1};
    vecs[4]  = '{C_SUB,  1'b0, 32'd3,         32'd5,         32'hFFFF_FFFE, 1'b0};
    vecs[5]  = '{C_SLT,  1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0};
    vecs[6]  = '{C_SLT,  1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1};
    vecs[7]  = '{C_NOR,  1'b0, 32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF, 1'b0};
    vecs[8]  = '{C_XOR,  1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0};
    vecs[9]  = '{C_SLL,  1'b0, 32'd4,         32'h0000_00F1, 32'h0000_0F10, 1'b0};
    vecs[10] = '{C_SRL,  1'b0, 32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0};
    vecs[11] = '{C_SRA,  1'b0, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0};
    vecs[12] = '{C_SRA,  1'b1, 32'h0000_0024, 32'h7000_0000, 32'h0700_0000, 1'b0};
    vecs[13] = '{C_MULT, 1'b1, 32'd9,         32'd9,         32'h0000_0000, 1'b1};
    vecs[14] = '{5'b11111, 1'b0, 32'd9,       32'd9,         32'h0000_0000, 1'b1};
    vecs[15] = '{C_MFHI, 1'b0, 32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0};
    vecs[16] = '{C_MFLO, 1'b0, 32'd0,         32'd0,         32'hFFFF_FFF1, 1'b0};

    #1 reset_n = 1'b0;
    ALUCtrl = C_MFHI;
    repeat (2) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_mfhi_out", 64'(out), 64'd0);
    check("reset_zero", {63'd0, zero}, 64'd1);
    reset_n = 1'b1;

    // Full-width unsigned product and the nominal latency
    launch(C_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE);
    wait_done(34, "mult_u");
    @(negedge clk);
    check("busy_after_fin", {63'd0, busy}, 64'd0);

    launch(C_MULT, 1'b1, -32'sd3, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    wait_done(34, "mult_s");
    @(negedge clk);
    ALUCtrl = C_MFLO;
    #1;
    check("mflo_out", 64'(out), 64'hFFFF_FFF1);
    check("mflo_zero", {63'd0, zero}, 64'd0);
    ALUCtrl = C_MFHI;
    #1;
    check("mfhi_out", 64'(out), 64'hFFFF_FFFF);

    // Combinational table while the divider runs; operands change under it
    launch(C_DIV, 1'b1, -32'sd7, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ALUCtrl = vecs[i].ctrl; Sign = vecs[i].sign; in1 = vecs[i].a; in2 = vecs[i].b;
      #1;
      check($sformatf("vec%0d_out", i), 64'(out), 64'(vecs[i].exp_out));
      check($sformatf("vec%0d_zero", i), {63'd0, zero}, {63'd0, vecs[i].exp_zero});
    end
    check("busy_during_table", {63'd0, busy}, 64'd1);
    wait_done(0, "div_s");

    launch(C_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000);
    wait_done(34, "div_minneg");
    launch(C_DIV, 1'b0, 32'h0000_1234, 32'd0, 1'b1, 32'h0000_1234, 32'hFFFF_FFFF);
    wait_done(34, "div_zero");
    launch(C_DIV, 1'b0, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14);
    wait_done(34, "div_u");
    launch(C_DIV, 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF);
    wait_done(34, "div_u_big");
    launch(C_DIV, 1'b1, 32'd7, -32'sd2, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD);
    wait_done(34, "div_s_negdiv");
    launch(C_MULT, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);
    wait_done(34, "mult_minneg");

    // Non-mult/div start in IDLE must not launch anything
    @(negedge clk);
    ALUCtrl = C_ADD; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("idle_add_start_ignored", {63'd0, busy}, 64'd1 - 64'd1);
    repeat (3) @(negedge clk);

    // Start in the 10th RUN cycle with fresh operands is dropped
    launch(C_MULT, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'h0000_0001, 32'h0000_0000);
    repeat (9) @(posedge clk);
    #1;
    ALUCtrl = C_DIV; Sign = 1'b1; in1 = 32'd99; in2 = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, "mult_ignore_start");
    repeat (40) @(negedge clk);
    check("no_extra_op_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of RUN
    snap = done_cnt;
    launch(C_DIV, 1'b0, 32'd1000, 32'd3, 1'b0, 32'd0, 32'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(snap));

    launch(C_MULT, 1'b0, 32'd6, 32'd7, 1'b1, 32'd0, 32'd42);
    wait_done(34, "mult_after_reset");

    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
